// File: rtl/heap_writer_pkg.sv
// Shared Lisp heap definitions: word layout, object type tags, header format
// and the payload size of each object type.
package lisp;

    localparam int word_size = 15;

    typedef logic [word_size:0]   word_t;
    typedef logic [word_size-1:0] tag_t;

    localparam tag_t TYPE_NUMBER = 15'd1;
    localparam tag_t TYPE_SYMBOL = 15'd2;
    localparam tag_t TYPE_CONS   = 15'd3;

    typedef struct packed {
        logic mark;
        tag_t tag;
    } header_t;

    // Words following the header; zero marks a tag the heap cannot store.
    function automatic logic [1:0] payload_words(input tag_t t);
        case (t)
            TYPE_NUMBER: payload_words = 2'd1;
            TYPE_SYMBOL: payload_words = 2'd1;
            TYPE_CONS:   payload_words = 2'd2;
            default:     payload_words = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/heap_writer.sv
// Bump-pointer object allocator: writes a header plus payload words into heap
// memory one word per cycle and returns the header address.
module heap_writer
    import lisp::*;
#(
    parameter int MemorySize = 1024,
    parameter int HeapBase   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_valid,
    output logic        alloc_ready,
    input  lisp::tag_t  alloc_type,
    input  logic [15:0] alloc_car,
    input  logic [15:0] alloc_cdr,
    output logic        done,
    output logic [15:0] ptr_out,
    output logic        err,
    output logic [15:0] free_ptr,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_P0,
        S_P1,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    tag_t        type_q;
    word_t       car_q, cdr_q;
    logic [1:0]  n_q;
    logic [15:0] free_q, free_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] addr_q, addr_d;
    word_t       wdata_q, wdata_d;
    logic        latch_req;
    logic [1:0]  n_in;
    logic [16:0] need_end;
    header_t     hdr;

    // Bound check runs in 17 bits so a pointer near 16'hFFFF cannot wrap into range.
    assign n_in     = payload_words(alloc_type);
    assign need_end = {1'b0, free_q} + 17'd1 + {15'd0, n_in};

    always_comb begin
        state_d   = state_q;
        free_d    = free_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        latch_req = 1'b0;
        hdr       = '{mark: 1'b0, tag: alloc_type};

        case (state_q)
            S_IDLE: begin
                if (alloc_valid) begin
                    if ((n_in == 2'd0) || (need_end > 17'(MemorySize))) begin
                        state_d = S_ERR;
                    end else begin
                        latch_req = 1'b1;
                        state_d   = S_HDR;
                        addr_d    = free_q;
                        wdata_d   = word_t'(hdr);
                    end
                end
            end
            S_HDR: begin
                state_d = S_P0;
                addr_d  = free_q + 16'd1;
                wdata_d = car_q;
            end
            S_P0: begin
                if (n_q == 2'd2) begin
                    state_d = S_P1;
                    addr_d  = free_q + 16'd2;
                    wdata_d = cdr_q;
                end else begin
                    state_d = S_DONE;
                    ptr_d   = free_q;
                    free_d  = free_q + 16'd1 + {14'd0, n_q};
                end
            end
            S_P1: begin
                state_d = S_DONE;
                ptr_d   = free_q;
                free_d  = free_q + 16'd1 + {14'd0, n_q};
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            free_q  <= 16'(HeapBase);
            ptr_q   <= 16'd0;
            addr_q  <= 16'd0;
            wdata_q <= '0;
            type_q  <= '0;
            car_q   <= '0;
            cdr_q   <= '0;
            n_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            free_q  <= free_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (latch_req) begin
                type_q <= alloc_type;
                car_q  <= alloc_car;
                cdr_q  <= alloc_cdr;
                n_q    <= n_in;
            end
        end
    end

    assign alloc_ready = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_ERR);
    assign mem_we      = (state_q == S_HDR) || (state_q == S_P0) || (state_q == S_P1);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign ptr_out     = ptr_q;
    assign free_ptr    = free_q;

endmodule

// File: tb/tb_heap_writer.sv
// Directed bench for heap_writer: a 1024-word heap and an 8-word heap, each
// backed by a behavioural memory captured from the write port.
module tb_heap_writer;
    import lisp::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        b_valid = 0, s_valid = 0;
    tag_t        b_type = '0, s_type = '0;
    logic [15:0] b_car = '0, b_cdr = '0, s_car = '0, s_cdr = '0;
    logic        b_ready, b_done, b_err, b_we;
    logic        s_ready, s_done, s_err, s_we;
    logic [15:0] b_ptr, b_free, b_addr, b_wdata;
    logic [15:0] s_ptr, s_free, s_addr, s_wdata;

    heap_writer #(.MemorySize(1024), .HeapBase(0)) u_big (
        .clk(clk), .rst(rst), .alloc_valid(b_valid), .alloc_ready(b_ready),
        .alloc_type(b_type), .alloc_car(b_car), .alloc_cdr(b_cdr),
        .done(b_done), .ptr_out(b_ptr), .err(b_err), .free_ptr(b_free),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata)
    );

    heap_writer #(.MemorySize(8), .HeapBase(0)) u_small (
        .clk(clk), .rst(rst), .alloc_valid(s_valid), .alloc_ready(s_ready),
        .alloc_type(s_type), .alloc_car(s_car), .alloc_cdr(s_cdr),
        .done(s_done), .ptr_out(s_ptr), .err(s_err), .free_ptr(s_free),
        .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata)
    );

    logic [15:0] b_mem [0:1023];
    logic [15:0] s_mem [0:7];
    int b_wcnt = 0, s_wcnt = 0;

    always @(posedge clk) begin
        if (b_we) begin
            b_mem[b_addr[9:0]] <= b_wdata;
            b_wcnt++;
        end
        if (s_we) begin
            s_mem[s_addr[2:0]] <= s_wdata;
            s_wcnt++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        tag_t        t;
        logic [15:0] car;
        logic [15:0] cdr;
        bit          exp_err;
        logic [15:0] exp_ptr;
        logic [15:0] exp_free;
        int          exp_lat;
    } vec_t;

    task automatic do_req(input bit sel, input vec_t v);
        int          lat;
        int          w0;
        int          nw;
        logic [15:0] p;
        lat = 0;
        @(negedge clk);
        check("ready_idle", sel ? s_ready : b_ready, 1);
        w0 = sel ? s_wcnt : b_wcnt;
        if (sel) begin
            s_valid = 1; s_type = v.t; s_car = v.car; s_cdr = v.cdr;
        end else begin
            b_valid = 1; b_type = v.t; b_car = v.car; b_cdr = v.cdr;
        end
        @(posedge clk);
        #1;
        // Disturb every request input after the accept edge.
        if (sel) begin
            s_valid = 0; s_type = 15'h5555; s_car = ~v.car; s_cdr = ~v.cdr;
        end else begin
            b_valid = 0; b_type = 15'h5555; b_car = ~v.car; b_cdr = ~v.cdr;
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (sel ? (s_done | s_err) : (b_done | b_err)) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, v.exp_lat);
        check("err_pulse", sel ? s_err : b_err, v.exp_err);
        check("ready_busy", sel ? s_ready : b_ready, 0);
        check("free_ptr", sel ? s_free : b_free, v.exp_free);
        nw = v.exp_err ? 0 : ((v.t == TYPE_CONS) ? 3 : 2);
        check("write_count", (sel ? s_wcnt : b_wcnt) - w0, nw);
        if (!v.exp_err) begin
            check("ptr_out", sel ? s_ptr : b_ptr, v.exp_ptr);
            p = v.exp_ptr;
            check("mem_hdr", sel ? s_mem[p[2:0]] : b_mem[p[9:0]], {1'b0, v.t});
            p = v.exp_ptr + 16'd1;
            check("mem_car", sel ? s_mem[p[2:0]] : b_mem[p[9:0]], v.car);
            if (v.t == TYPE_CONS) begin
                p = v.exp_ptr + 16'd2;
                check("mem_cdr", sel ? s_mem[p[2:0]] : b_mem[p[9:0]], v.cdr);
            end
        end
    endtask

    vec_t big_tbl [6];
    vec_t small_tbl [5];

    initial begin
        int          w0;
        int          acc;
        int          ndone;
        int          acc_cyc [3];
        bit          r;

        //            tag          car       cdr       err ptr    free   lat
        big_tbl[0] = '{TYPE_NUMBER, 16'h2A2A, 16'h0000, 0, 16'd0, 16'd2,  3};
        big_tbl[1] = '{TYPE_CONS,   16'h0000, 16'h0000, 0, 16'd2, 16'd5,  4};
        big_tbl[2] = '{TYPE_SYMBOL, 16'h0042, 16'h9999, 0, 16'd5, 16'd7,  3};
        big_tbl[3] = '{15'h007F,    16'h1111, 16'h2222, 1, 16'd0, 16'd7,  1};
        big_tbl[4] = '{TYPE_CONS,   16'h1234, 16'hABCD, 0, 16'd7, 16'd10, 4};
        big_tbl[5] = '{15'h0000,    16'h3333, 16'h4444, 1, 16'd0, 16'd10, 1};

        small_tbl[0] = '{TYPE_CONS,   16'hAAAA, 16'hBBBB, 0, 16'd0, 16'd3, 4};
        small_tbl[1] = '{TYPE_CONS,   16'hCCCC, 16'hDDDD, 0, 16'd3, 16'd6, 4};
        small_tbl[2] = '{TYPE_NUMBER, 16'hEEEE, 16'h0000, 0, 16'd6, 16'd8, 3};
        small_tbl[3] = '{TYPE_NUMBER, 16'h0101, 16'h0000, 1, 16'd0, 16'd8, 1};
        small_tbl[4] = '{TYPE_SYMBOL, 16'h0202, 16'h0000, 1, 16'd0, 16'd8, 1};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_ready", b_ready, 1);
        check("rst_done", b_done, 0);
        check("rst_err", b_err, 0);
        check("rst_ptr", b_ptr, 0);
        check("rst_free", b_free, 0);
        check("rst_we", b_we, 0);
        check("rst_addr", b_addr, 0);
        check("rst_wdata", b_wdata, 0);

        for (int i = 0; i < 6; i++) do_req(1'b0, big_tbl[i]);
        for (int i = 0; i < 5; i++) do_req(1'b1, small_tbl[i]);

        // Reset while the car word of a cons is on the write port.
        @(negedge clk);
        b_valid = 1; b_type = TYPE_CONS; b_car = 16'h1111; b_cdr = 16'h2222;
        @(posedge clk);
        #1 b_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_p0_we", b_we, 1);
        rst = 1;
        @(posedge clk);
        #1 w0 = b_wcnt;
        @(negedge clk);
        check("midrst_we_in_rst", b_we, 0);
        rst = 0;
        @(negedge clk);
        check("midrst_we_after", b_we, 0);
        check("midrst_free", b_free, 0);
        check("midrst_ready", b_ready, 1);
        repeat (4) @(negedge clk);
        check("midrst_no_writes", b_wcnt - w0, 0);
        check("midrst_still_idle", b_ready, 1);

        // Valid held high across three NUMBER requests; car changes after each accept.
        acc = 0;
        ndone = 0;
        for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
        b_valid = 1; b_type = TYPE_NUMBER; b_car = 16'hC000;
        for (int cyc = 0; cyc < 40 && ndone < 3; cyc++) begin
            r = b_ready;
            if (b_done) begin
                check("held_ptr", b_ptr, ndone * 2);
                ndone++;
            end
            @(posedge clk);
            #1;
            if (r && b_valid) begin
                acc_cyc[acc] = cyc;
                acc++;
                b_car = 16'hC000 + 16'(acc);
                if (acc == 3) b_valid = 0;
            end
            @(negedge clk);
        end
        check("held_done_count", ndone, 3);
        check("held_gap01", acc_cyc[1] - acc_cyc[0], 4);
        check("held_gap12", acc_cyc[2] - acc_cyc[1], 4);
        check("held_mem1", b_mem[1], 16'hC000);
        check("held_mem3", b_mem[3], 16'hC001);
        check("held_mem5", b_mem[5], 16'hC002);
        check("held_free", b_free, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
